// File: rtl/pio_tx_inject.sv
// Replays framed TLPs from the 72-bit {tkeep,tdata} tunnel FIFO onto the PCIe AXIS TX port.
// Optional `PIO_TX_INJECT_STATS_EN adds tx_pkt_count / drop_pkt_count outputs.
module pio_tx_inject #(
  parameter int MAX_PAYLOAD_DW = 1024
) (
  input  logic        clk,
  input  logic        sys_rst,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  output logic [3:0]  s_axis_tx_tuser,
`ifdef PIO_TX_INJECT_STATS_EN
  output logic [31:0] tx_pkt_count,
  output logic [31:0] drop_pkt_count,
`endif
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en
);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_e;

  localparam logic [31:0] MAX_PAY = MAX_PAYLOAD_DW;

  state_e      state_q, state_d;
  logic [10:0] rem_q, rem_d;
  logic [63:0] tdata_q;
  logic [7:0]  tkeep_q;
  logic        tlast_q, tvalid_q;
  logic        load, last_d, rd_raw;

  logic        gap, free;
  logic [1:0]  fmt;
  logic [10:0] len_dw, pay_dw, beats;
  logic [11:0] dw_sum;
  logic        oversize;

  assign gap  = (dout[71:64] == 8'h00);
  assign free = !tvalid_q || s_axis_tx_tready;

  // Header decode on the FIFO head; only meaningful in IDLE on a non-gap word.
  always_comb begin
    fmt      = dout[30:29];
    len_dw   = (dout[9:0] == 10'd0) ? 11'd1024 : {1'b0, dout[9:0]};
    pay_dw   = fmt[1] ? len_dw : 11'd0;
    dw_sum   = (fmt[0] ? 12'd4 : 12'd3) + {1'b0, pay_dw} + 12'd1;
    beats    = dw_sum[11:1];
    oversize = 32'(pay_dw) > MAX_PAY;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rd_raw  = 1'b0;
    load    = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        if (gap) begin
          rd_raw = 1'b1;
        end else if (oversize) begin
          rd_raw  = 1'b1;
          rem_d   = beats - 11'd1;
          state_d = DROP;
        end else if (free) begin
          rd_raw  = 1'b1;
          load    = 1'b1;
          rem_d   = beats - 11'd1;
          state_d = DATA;
        end
      end
      DATA: if (!empty) begin
        if (gap) begin
          rd_raw = 1'b1;
        end else if (free) begin
          rd_raw = 1'b1;
          load   = 1'b1;
          rem_d  = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP: if (!empty) begin
        // Drain ignores tready so an oversize TLP never stalls the tunnel.
        rd_raw = 1'b1;
        if (!gap) begin
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en = rd_raw && !sys_rst;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (load) begin
        tdata_q  <= dout[63:0];
        tkeep_q  <= dout[71:64];
        tlast_q  <= last_d;
        tvalid_q <= 1'b1;
      end else if (s_axis_tx_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tvalid = tvalid_q;
  assign s_axis_tx_tuser  = 4'b0000;

`ifdef PIO_TX_INJECT_STATS_EN
  logic [31:0] tx_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (tvalid_q && s_axis_tx_tready && tlast_q) tx_cnt_q <= tx_cnt_q + 32'd1;
      if (state_q != DROP && state_d == DROP)      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign tx_pkt_count   = tx_cnt_q;
  assign drop_pkt_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pio_tx_inject.sv
// Directed bench for pio_tx_inject: FIFO queue model feeding two instances
// (default and 32-DW payload limit), AXIS beat scoreboard against hand-built words.
module tb_pio_tx_inject;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        tready;
  logic        sel;
  logic [71:0] dout = '0;
  logic        fifo_empty = 1'b1;

  logic [63:0] tdata_a, tdata_b;
  logic [7:0]  tkeep_a, tkeep_b;
  logic        tlast_a, tlast_b, tvalid_a, tvalid_b, rd_en_a, rd_en_b;
  logic [3:0]  tuser_a, tuser_b;
  logic        empty_a, empty_b;
`ifdef PIO_TX_INJECT_STATS_EN
  logic [31:0] txc_a, drc_a, txc_b, drc_b;
`endif

  always #5 clk = ~clk;

  assign empty_a = sel  || fifo_empty;
  assign empty_b = !sel || fifo_empty;

  pio_tx_inject #(.MAX_PAYLOAD_DW(1024)) u_a (
    .clk(clk), .sys_rst(sys_rst),
    .s_axis_tx_tdata(tdata_a), .s_axis_tx_tkeep(tkeep_a), .s_axis_tx_tlast(tlast_a),
    .s_axis_tx_tvalid(tvalid_a), .s_axis_tx_tready(tready), .s_axis_tx_tuser(tuser_a),
`ifdef PIO_TX_INJECT_STATS_EN
    .tx_pkt_count(txc_a), .drop_pkt_count(drc_a),
`endif
    .dout(dout), .empty(empty_a), .rd_en(rd_en_a));

  pio_tx_inject #(.MAX_PAYLOAD_DW(32)) u_b (
    .clk(clk), .sys_rst(sys_rst),
    .s_axis_tx_tdata(tdata_b), .s_axis_tx_tkeep(tkeep_b), .s_axis_tx_tlast(tlast_b),
    .s_axis_tx_tvalid(tvalid_b), .s_axis_tx_tready(tready), .s_axis_tx_tuser(tuser_b),
`ifdef PIO_TX_INJECT_STATS_EN
    .tx_pkt_count(txc_b), .drop_pkt_count(drc_b),
`endif
    .dout(dout), .empty(empty_b), .rd_en(rd_en_b));

  logic [63:0] tdata_s;
  logic [7:0]  tkeep_s;
  logic        tlast_s, tvalid_s, rd_en_s, empty_s;
  assign tdata_s  = sel ? tdata_b  : tdata_a;
  assign tkeep_s  = sel ? tkeep_b  : tkeep_a;
  assign tlast_s  = sel ? tlast_b  : tlast_a;
  assign tvalid_s = sel ? tvalid_b : tvalid_a;
  assign rd_en_s  = sel ? rd_en_b  : rd_en_a;
  assign empty_s  = sel ? empty_b  : empty_a;

  // FWFT FIFO model: main process pushes, this process pops on rd_en.
  logic [71:0] fifo[$];
  int pops = 0;
  always @(posedge clk) begin
    if (rd_en_s && !fifo_empty) begin
      void'(fifo.pop_front());
      pops <= pops + 1;
    end
    dout       <= (fifo.size() != 0) ? fifo[0] : 72'h0;
    fifo_empty <= (fifo.size() == 0);
  end

  // Beat monitor: sampled mid-cycle; a beat is taken at the following posedge.
  logic [72:0] outq[$];
  int outcyc[$];
  int cyc = 0, vcyc = 0, viol = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tvalid_s) vcyc <= vcyc + 1;
    if (tvalid_s && tready) begin
      outq.push_back({tlast_s, tkeep_s, tdata_s});
      outcyc.push_back(cyc);
    end
    if (rd_en_s && empty_s) viol <= viol + 1;
  end

  logic [72:0] expq[$];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int mism(input int ob, input int eb, input int n);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (outq[ob+i] !== expq[eb+i]) m++;
    return m;
  endfunction

  task automatic push_tlp(input logic [1:0] fmt, input logic [9:0] len, input int nwords,
                          input logic [7:0] lastkeep, input int gaps, input int midgap,
                          input logic [15:0] tag, input bit expect_out);
    logic [71:0] w;
    for (int g = 0; g < gaps; g++) fifo.push_back({8'h00, 48'hDEAD_0000_0000, 16'(g)});
    for (int i = 0; i < nwords; i++) begin
      if (i == midgap) fifo.push_back({8'h00, 64'hDEAD_BEEF_0000_0001});
      if (i == 0) w = {8'hFF, 16'hA5A5, tag, 1'b0, fmt, 19'd0, len};
      else        w = {(i == nwords-1) ? lastkeep : 8'hFF, 16'hBEEF, tag, 16'h0, 16'(i)};
      fifo.push_back(w);
      if (expect_out) expq.push_back({i == nwords-1, w});
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (outq.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] fmt;
    logic [9:0] len;
    int         gaps;
    int         midgap;
    logic [7:0] lastkeep;
    int         exp_beats;
    int         exp_pops;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int ob, eb, p0, v0, bad, nb;
    tbl[0] = '{2'b10, 10'd1,  3, -1,  8'hFF, 2,   5};    // MWr32 1DW behind 3 gaps
    tbl[1] = '{2'b01, 10'd16, 0, -1,  8'hFF, 2,   2};    // MRd64
    tbl[2] = '{2'b00, 10'd1,  0, -1,  8'h0F, 2,   2};    // MRd32, odd DW
    tbl[3] = '{2'b11, 10'd3,  1, -1,  8'h0F, 4,   5};    // MWr64 3DW
    tbl[4] = '{2'b10, 10'd8,  0, -1,  8'h0F, 6,   6};    // MWr32 8DW
    tbl[5] = '{2'b10, 10'd0,  0, 200, 8'h0F, 514, 515};  // len=0 -> 1024DW, gap mid-packet

    sys_rst = 1'b1; tready = 1'b1; sel = 1'b0;
    #12;
    check("rst_tvalid", 64'(tvalid_a), 64'd0);
    check("rst_tdata",  tdata_a, 64'd0);
    check("rst_tkeep",  64'(tkeep_a), 64'd0);
    check("rst_tlast",  64'(tlast_a), 64'd0);
    check("rst_rd_en",  64'(rd_en_a), 64'd0);
    check("rst_tuser",  64'({tuser_a, tuser_b}), 64'd0);
`ifdef PIO_TX_INJECT_STATS_EN
    check("rst_counts", {txc_a, drc_b}, 64'd0);
`endif
    @(negedge clk); sys_rst = 1'b0;

    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      ob = outq.size(); eb = expq.size(); p0 = pops;
      push_tlp(tbl[r].fmt, tbl[r].len, tbl[r].exp_beats, tbl[r].lastkeep,
               tbl[r].gaps, tbl[r].midgap, 16'(r), 1'b1);
      wait_beats(ob + tbl[r].exp_beats, 1500);
      nb = outq.size() - ob;
      check($sformatf("vec%0d_beats", r), 64'(nb), 64'(tbl[r].exp_beats));
      check($sformatf("vec%0d_data_tlast", r), 64'(mism(ob, eb, tbl[r].exp_beats)), 64'd0);
      check($sformatf("vec%0d_pops", r), 64'(pops - p0), 64'(tbl[r].exp_pops));
    end

    // Two MRd64 back to back: four beats on consecutive cycles.
    @(posedge clk); #1;
    ob = outq.size(); eb = expq.size();
    push_tlp(2'b01, 10'd16, 2, 8'hFF, 0, -1, 16'h0B0B, 1'b1);
    push_tlp(2'b01, 10'd16, 2, 8'hFF, 0, -1, 16'h0C0C, 1'b1);
    wait_beats(ob + 4, 100);
    check("b2b_beats", 64'(outq.size() - ob), 64'd4);
    check("b2b_data", 64'(mism(ob, eb, 4)), 64'd0);
    check("b2b_no_bubble", 64'(outcyc[ob+3] - outcyc[ob]), 64'd3);

    // Backpressure on beat 3 of a 6-beat MWr.
    @(posedge clk); #1;
    ob = outq.size(); eb = expq.size();
    push_tlp(2'b10, 10'd8, 6, 8'h0F, 0, -1, 16'h0D0D, 1'b1);
    nb = 0;
    while (outq.size() < ob + 2 && nb < 100) begin @(posedge clk); #1; nb++; end
    tready = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tdata_s !== expq[eb+2][63:0] || rd_en_s !== 1'b0 || tvalid_s !== 1'b1) bad++;
    end
    check("bp_hold_beat3", 64'(bad), 64'd0);
    @(posedge clk); #1; tready = 1'b1;
    wait_beats(ob + 6, 100);
    check("bp_beats", 64'(outq.size() - ob), 64'd6);
    check("bp_data", 64'(mism(ob, eb, 6)), 64'd0);

    // Oversize MWr (64DW > 32) dropped whole on instance B, then an MRd passes.
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    ob = outq.size(); eb = expq.size(); p0 = pops; v0 = vcyc;
    push_tlp(2'b10, 10'd64, 34, 8'h0F, 0, -1, 16'h0E0E, 1'b0);
    push_tlp(2'b01, 10'd16, 2, 8'hFF, 0, -1, 16'h0F0F, 1'b1);
    wait_beats(ob + 2, 200);
    check("drop_beats", 64'(outq.size() - ob), 64'd2);
    check("drop_data", 64'(mism(ob, eb, 2)), 64'd0);
    check("drop_pops", 64'(pops - p0), 64'd36);
    check("drop_valid_cycles", 64'(vcyc - v0), 64'd2);
`ifdef PIO_TX_INJECT_STATS_EN
    check("drop_count", 64'(drc_b), 64'd1);
    check("drop_tx_count", 64'(txc_b), 64'd1);
`endif

    // Reset while beat 3 of a 6-beat TLP sits on the output.
    @(posedge clk); #1;
    sel = 1'b0;
    @(posedge clk); #1;
    ob = outq.size();
    fifo.push_back({8'hFF, 32'hC0DE_0000, 32'h4000_0008});
    fifo.push_back({8'hFF, 64'hC0DE_0000_0000_0001});
    fifo.push_back({8'hFF, 64'hC0DE_0000_0000_0002});
    nb = 0;
    while (outq.size() < ob + 2 && nb < 100) begin @(posedge clk); #1; nb++; end
    #2 sys_rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid_a), 64'd0);
    check("mid_rst_tdata", tdata_a, 64'd0);
    check("mid_rst_keep_last", 64'({tkeep_a, tlast_a}), 64'd0);
    check("mid_rst_rd_en", 64'(rd_en_a), 64'd0);
`ifdef PIO_TX_INJECT_STATS_EN
    check("mid_rst_tx_count", 64'(txc_a), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); sys_rst = 1'b0;
    @(posedge clk); #1;
    ob = outq.size(); eb = expq.size();
    push_tlp(2'b01, 10'd16, 2, 8'hFF, 0, -1, 16'h1111, 1'b1);
    wait_beats(ob + 2, 100);
    check("post_rst_beats", 64'(outq.size() - ob), 64'd2);
    check("post_rst_data", 64'(mism(ob, eb, 2)), 64'd0);
`ifdef PIO_TX_INJECT_STATS_EN
    check("post_rst_tx_count", 64'(txc_a), 64'd1);
`endif
    check("never_pop_empty", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
